// File: rtl/instr_fetch_unit.sv
// Instruction fetch: holds the PC, fetches over an IMEM req/ack handshake and hands {instr, iaddr} to decode.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect parks the unit in ERR with a sticky fetch_err.
//
// state | meaning
// IDLE  | one-cycle settle after reset release, IMEM ack ignored
// REQ   | request outstanding at pc, waiting for imem_ack
// HOLD  | instr/iaddr valid, waiting for downstream instr_ready
// ERR   | misaligned redirect trap, left only by reset (trap build only)
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic [31:0] iaddr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] iaddr_q;
    logic [31:0] pc_next;

    // Low address bits are dropped so the PC can never hold a misaligned value.
    assign pc_next = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : (pc + 32'd4);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign;
    logic err_q;
    assign misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    state_nxt = misalign ? S_ERR : S_REQ;
`else
                    state_nxt = S_REQ;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_ERR: state_nxt = S_ERR;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            instr_q <= NOP_INSTR;
            iaddr_q <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        iaddr_q <= pc;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        // Faulting target is reported on iaddr for the trap handler.
                        if (misalign) begin
                            iaddr_q <= redirect_pc;
                            err_q   <= 1'b1;
                        end else begin
                            pc <= pc_next;
                        end
`else
                        pc <= pc_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr   = pc;
    assign imem_req    = (state == S_REQ);
    assign instr_valid = (state == S_HOLD);
    assign instr       = instr_valid ? instr_q : NOP_INSTR;
    assign iaddr       = iaddr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table of fetch/consume vectors against a wait-state IMEM model,
// plus directed sequences for misaligned redirect and reset during an outstanding request.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic [31:0] iaddr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    int   wait_cfg  = 0;
    int   wait_cnt  = 0;
    logic ack_force = 1'b0;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .instr         (instr),
        .iaddr         (iaddr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_err     (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0003;
    endfunction

    // IMEM model: acks after wait_cfg stalled cycles of an active request.
    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = ack_force | (imem_req && (wait_cnt >= wait_cfg));

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for instr_valid while driving redirect/ready noise that must be ignored.
    task automatic wait_valid(output int reqc, output logic held_ok);
        logic [31:0] a0;
        logic        done;
        reqc    = 0;
        held_ok = 1'b1;
        a0      = 32'h0;
        done    = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            if (instr_valid) begin
                done = 1'b1;
            end else begin
                if (imem_req) begin
                    if (reqc == 0) a0 = imem_addr;
                    else if (imem_addr !== a0) held_ok = 1'b0;
                    reqc++;
                end
                instr_ready    = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0200;
                @(negedge clk);
            end
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL wait_valid: got timeout expected instr_valid");
        end
    endtask

    typedef struct {
        int          wait_n;
        int          hold_n;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] exp_iaddr;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vec[10];

    initial begin
        int          reqc;
        logic        held_ok;
        logic [31:0] ia;

        vec[0] = '{0, 0, 1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004};
        vec[1] = '{0, 0, 1'b0, 32'h0,         32'h0000_0004, 32'h0000_0008};
        vec[2] = '{0, 0, 1'b0, 32'h0,         32'h0000_0008, 32'h0000_000C};
        vec[3] = '{0, 0, 1'b0, 32'h0,         32'h0000_000C, 32'h0000_0010};
        vec[4] = '{3, 2, 1'b0, 32'h0,         32'h0000_0010, 32'h0000_0014};
        vec[5] = '{0, 0, 1'b1, 32'h100,       32'h0000_0014, 32'h0000_0100};
        vec[6] = '{0, 0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0100, 32'hFFFF_FFFC};
        vec[7] = '{0, 0, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000};
        vec[8] = '{1, 0, 1'b1, 32'h40,        32'h0000_0000, 32'h0000_0040};
        vec[9] = '{0, 1, 1'b1, 32'h80,        32'h0000_0040, 32'h0000_0080};

        reset          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req",   {31'b0, imem_req},    32'd0);
        chk("rst_addr",  imem_addr,            32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr,                NOP);
        chk("rst_iaddr", iaddr,                32'h0);
        chk("rst_err",   {31'b0, fetch_err},   32'd0);

        reset = 1'b1;
        @(negedge clk);
        chk("first_req",  {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr,         32'h0);

        for (int i = 0; i < 10; i++) begin
            wait_cfg = vec[i].wait_n;
            wait_valid(reqc, held_ok);
            chk($sformatf("v%0d_reqcyc", i), reqc, vec[i].wait_n + 1);
            chk($sformatf("v%0d_held", i), {31'b0, held_ok}, 32'd1);
            chk($sformatf("v%0d_iaddr", i), iaddr, vec[i].exp_iaddr);
            chk($sformatf("v%0d_instr", i), instr, mem_word(vec[i].exp_iaddr));
            chk($sformatf("v%0d_noreq", i), {31'b0, imem_req}, 32'd0);
            instr_ready    = 1'b0;
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_0300;
            for (int h = 0; h < vec[i].hold_n; h++) begin
                @(negedge clk);
                chk($sformatf("v%0d_h_iaddr", i), iaddr, vec[i].exp_iaddr);
                chk($sformatf("v%0d_h_instr", i), instr, mem_word(vec[i].exp_iaddr));
                chk($sformatf("v%0d_h_req", i), {31'b0, imem_req}, 32'd0);
                chk($sformatf("v%0d_h_valid", i), {31'b0, instr_valid}, 32'd1);
            end
            instr_ready    = 1'b1;
            redirect_valid = vec[i].rv;
            redirect_pc    = vec[i].rpc;
            @(negedge clk);
            chk($sformatf("v%0d_next", i), imem_addr, vec[i].exp_next);
            chk($sformatf("v%0d_nreq", i), {31'b0, imem_req}, 32'd1);
            chk($sformatf("v%0d_nvalid", i), {31'b0, instr_valid}, 32'd0);
            chk($sformatf("v%0d_nop", i), instr, NOP);
        end

        // Misaligned redirect from the instruction at 0x80.
        wait_cfg = 0;
        wait_valid(reqc, held_ok);
        ia = iaddr;
        chk("mis_iaddr", ia, 32'h0000_0080);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        @(negedge clk);
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_err",   {31'b0, fetch_err},   32'd1);
        chk("mis_taddr", iaddr,                32'h0000_0102);
        chk("mis_req",   {31'b0, imem_req},    32'd0);
        chk("mis_valid", {31'b0, instr_valid}, 32'd0);
        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        ack_force = 1'b0;
        chk("err_sticky", {31'b0, fetch_err},   32'd1);
        chk("err_req",    {31'b0, imem_req},    32'd0);
        chk("err_valid",  {31'b0, instr_valid}, 32'd0);
`else
        chk("mis_addr", imem_addr,          32'h0000_0100);
        chk("mis_req",  {31'b0, imem_req},  32'd1);
        chk("mis_err",  {31'b0, fetch_err}, 32'd0);
        wait_cfg = 20;
        @(negedge clk);
        chk("stall_req",  {31'b0, imem_req}, 32'd1);
        chk("stall_addr", imem_addr,         32'h0000_0100);
`endif

        // Reset with no ack yet; the ack then lands in IDLE and must be dropped.
        reset = 1'b0;
        #1;
        chk("mrst_req",   {31'b0, imem_req},    32'd0);
        chk("mrst_addr",  imem_addr,            32'h0);
        chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mrst_err",   {31'b0, fetch_err},   32'd0);
        @(negedge clk);
        reset     = 1'b1;
        ack_force = 1'b1;
        wait_cfg  = 0;
        @(negedge clk);
        ack_force = 1'b0;
        chk("late_req",   {31'b0, imem_req},    32'd1);
        chk("late_addr",  imem_addr,            32'h0);
        chk("late_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        chk("refetch_valid", {31'b0, instr_valid}, 32'd1);
        chk("refetch_iaddr", iaddr,                32'h0);
        chk("refetch_instr", instr,                mem_word(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
